aes_subbytes_seq: RTL and testbench

Sequential forward AES SubBytes engine for the encryption datapath, the counterpart of the inverse substitution used in decryption. It accepts a 128-bit AES state over a valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per clock through the FIPS-197 forward S-box. It returns the full substituted state over a second valid/ready handshake. It sits between AddRoundKey and ShiftRows in the round pipeline, or replaces both stages when ShiftRows is fused in (see Configuration).

---
 rtl/aes_subbytes_seq.sv | 140 ++++++++++++++
 tb/tb_aes_subbytes_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_subbytes_seq.sv
// Sequential forward AES SubBytes: BYTES_PER_CYCLE S-box lookups per clock over a 128-bit state.
// Define AES_SUBBYTES_SHIFTROWS_EN to fuse ShiftRows onto the result.
module aes_subbytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
        $error("aes_subbytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_t;

    // The step wraps to 0 for 16 bytes/cycle, which is harmless because SUB then lasts one cycle.
    localparam logic [3:0] IDX_STEP = 4'(BYTES_PER_CYCLE);
    localparam logic [3:0] LAST_IDX = 4'(16 - BYTES_PER_CYCLE);

    // FIPS-197 forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                t[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return t;
    endfunction

    state_t         r_fsm;
    logic [3:0]     r_idx;
    logic [127:0]   r_work;
    logic           r_in_ready;
    logic           r_out_valid;
    logic           r_busy;
    logic [127:0]   w_work_next;

    always_comb begin
        // NOTE: default assignment first, so partial updates never infer a latch.
        w_work_next = r_work;
        for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
            w_work_next[127 - 8*(int'(r_idx) + k) -: 8] =
                sbox(r_work[127 - 8*(int'(r_idx) + k) -: 8]);
        end
    end

    // NOTE: non-blocking assignments for every register so all state updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_idx       <= '0;
            r_work      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_work     <= state_in;
                        r_idx      <= '0;
                        r_fsm      <= SUB;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                SUB: begin
                    r_work <= w_work_next;
                    r_idx  <= r_idx + IDX_STEP;
                    if (r_idx == LAST_IDX) begin
                        r_fsm       <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_fsm       <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_fsm       <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

`ifdef AES_SUBBYTES_SHIFTROWS_EN
    assign state_out = shift_rows(r_work);
`else
    assign state_out = r_work;
`endif

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Scoreboard bench for aes_subbytes_seq: directed vectors, backpressure, reset, sweep over widths.
module tb_aes_subbytes_seq;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    always #5 clk = ~clk;

    aes_subbytes_seq #(.BYTES_PER_CYCLE(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    // Extra instances for the other widths: index 0..3 -> 1, 2, 8, 16 bytes per cycle.
    logic         sw_in_valid  [4];
    logic         sw_in_ready  [4];
    logic         sw_out_valid [4];
    logic [127:0] sw_state_out [4];
    logic         sw_busy      [4];
    logic [127:0] sw_state_in;

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        aes_subbytes_seq #(.BYTES_PER_CYCLE((g < 2) ? (1 << g) : (1 << (g + 1)))) u_sw (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (sw_in_valid[g]),
            .in_ready  (sw_in_ready[g]),
            .state_in  (sw_state_in),
            .out_valid (sw_out_valid[g]),
            .out_ready (1'b1),
            .state_out (sw_state_out[g]),
            .busy      (sw_busy[g])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: GF(2^8) inverse followed by the affine transform.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < 254; i++) v = gmul(v, x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_out(input logic [127:0] s);
        logic [127:0] t;
        logic [127:0] u;
        for (int i = 0; i < 16; i++) t[127 - 8*i -: 8] = sbox_model(s[127 - 8*i -: 8]);
        u = t;
`ifdef AES_SUBBYTES_SHIFTROWS_EN
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                u[127 - 8*(4*c + r) -: 8] = t[127 - 8*(4*((c + r) % 4) + r) -: 8];
`endif
        return u;
    endfunction

    typedef struct {
        logic [127:0] data;
        int           acc_cyc;
    } sb_t;

    sb_t  sb_q[$];
    logic lat_seen = 1'b0;

    // Monitor: compares whenever the DUT presents a result.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out_valid", out_valid, 1'b0);
            end else begin
                if (!lat_seen) begin
                    check("latency", cyc - sb_q[0].acc_cyc, LAT);
                    lat_seen = 1'b1;
                end
                if (out_ready) begin
                    check("data", state_out, sb_q[0].data);
                    void'(sb_q.pop_front());
                    lat_seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [127:0] s, input logic [127:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", in_ready, 1'b1);
            return;
        end
        state_in = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        sb_q.push_back('{exp, cyc});
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic sweep(input int k, input logic [127:0] s, input logic [127:0] exp);
        int n;
        int bpc;
        bpc = (k < 2) ? (1 << k) : (1 << (k + 1));
        n = 0;
        @(negedge clk);
        check($sformatf("sweep%0d_in_ready", bpc), sw_in_ready[k], 1'b1);
        sw_state_in    = s;
        sw_in_valid[k] = 1'b1;
        @(posedge clk);
        #1;
        sw_in_valid[k] = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!sw_out_valid[k] && n < 40);
        check($sformatf("sweep%0d_latency", bpc), n - 1, 16 / bpc);
        check($sformatf("sweep%0d_data", bpc), sw_state_out[k], exp);
    endtask

    localparam logic [127:0] APPB_IN = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
`ifdef AES_SUBBYTES_SHIFTROWS_EN
    localparam logic [127:0] APPB_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`else
    localparam logic [127:0] APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
`endif
    localparam logic [127:0] ALL63 = {16{8'h63}};
    localparam logic [127:0] ALL16 = {16{8'h16}};

    logic [127:0] stream [8] = '{
        128'h00112233445566778899aabbccddeeff,
        128'h0123456789abcdeffedcba9876543210,
        128'h3243f6a8885a308d313198a2e0370734,
        128'hdeadbeefcafef00d0badc0de12345678,
        128'h5353535353535353530153ff00010203,
        128'hffeeddccbbaa99887766554433221100,
        128'h8e73b0f7da0e6452c810f32b809079e5,
        128'h1f2e3d4c5b6a79880796a5b4c3d2e1f0
    };

    initial begin
        int n;
        int prev;
        logic [127:0] bp_exp;

        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        state_in    = '0;
        sw_state_in = '0;
        for (int i = 0; i < 4; i++) sw_in_valid[i] = 1'b0;

        #12;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_state_out", state_out, 128'h0);
        @(negedge clk);
        rst = 1'b0;

        send(APPB_IN, APPB_OUT);
        send(128'h0, ALL63);
        send({128{1'b1}}, ALL16);

        for (int k = 0; k < 4; k++) begin
            sweep(k, 128'h0, ALL63);
            sweep(k, {128{1'b1}}, ALL16);
        end

        // Backpressure: stall in DONE for 10 cycles with a competing input offered.
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        bp_exp = ref_out(stream[2]);
        send(stream[2], bp_exp);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        check("bp_out_valid_rise", out_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            state_in = stream[3];
            in_valid = 1'b1;
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_state_out", state_out, bp_exp);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_busy", busy, 1'b1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(stream[3], ref_out(stream[3]));

        // Reset two cycles after acceptance discards the in-flight state.
        send(stream[4], ref_out(stream[4]));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_in_ready", in_ready, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        send(APPB_IN, APPB_OUT);

        // Back-to-back stream: one acceptance every 6 cycles.
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 8; i++) begin
            prev = last_acc;
            send(stream[i], ref_out(stream[i]));
            if (i > 0) check($sformatf("stream_spacing%0d", i), last_acc - prev, 6);
        end

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
